// File: rtl/dual_ser_pkg.sv
// Shared types and constants for the dual-stream serializer.
//   state_e   : serializer FSM states (IDLE: line quiet, SHIFT: a frame bit is on the line)
//   DEF_WIDTH : default bits per word per stream
//   cnt_width : width of the in-frame bit counter for a given word width
// Optional feature macro: DUAL_SER_PARITY_EN (see dual_seq_serializer.sv).
package dual_ser_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam int unsigned DEF_WIDTH = 32;

    // Wide enough to count to WIDTH, which the parity bit index needs.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/dual_seq_serializer_if.sv
// Word-pair input handshake plus serial output side of the dual-stream serializer.
//   in_valid/in_ready   : pair handshake, transfer on an edge where both are high
//   in_word1/in_word2   : words for stream 1 / stream 2
//   out_en              : downstream advance enable
//   seq1/seq2           : serial streams, MSB first
//   bit_valid           : a real bit is on seq1/seq2 this cycle
//   frame_start/_last   : current bit is first / last of a frame
// Modports: master drives the word side and out_en, slave is the serializer.
// Optional feature macro: DUAL_SER_PARITY_EN (no effect on this interface).
interface dual_seq_serializer_if #(
    parameter int unsigned WIDTH = dual_ser_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word1;
    logic [WIDTH-1:0] in_word2;
    logic             out_en;
    logic             seq1;
    logic             seq2;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_last;

    modport master (
        output in_valid, in_word1, in_word2, out_en,
        input  in_ready, seq1, seq2, bit_valid, frame_start, frame_last
    );

    modport slave (
        input  in_valid, in_word1, in_word2, out_en,
        output in_ready, seq1, seq2, bit_valid, frame_start, frame_last
    );

endinterface

// File: rtl/ser_shift_lane.sv
// One serializer lane: holding-buffer word, MSB-first shift register and,
// with DUAL_SER_PARITY_EN defined, an even-parity flop captured at load.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   capture   : write word into the holding buffer
//   load      : move holding buffer into the shift register
//   shift     : shift left by one, zero fill
//   clear     : clear the shift register
//   par_sel   : (parity builds only) drive the parity flop instead of the MSB
//   word      : incoming word
//   bit_out   : serial bit
module ser_shift_lane #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
`ifdef DUAL_SER_PARITY_EN
    input  logic             par_sel,
`endif
    input  logic [WIDTH-1:0] word,
    output logic             bit_out
);

    logic [WIDTH-1:0] hb_q;
    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_q <= '0;
        end else if (capture) begin
            hb_q <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= hb_q;
        end else if (shift) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end else if (clear) begin
            sr_q <= '0;
        end
    end

`ifdef DUAL_SER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^hb_q;
        end
    end

    assign bit_out = par_sel ? par_q : sr_q[WIDTH-1];
`else
    assign bit_out = sr_q[WIDTH-1];
`endif

endmodule

// File: rtl/dual_seq_serializer.sv
// Dual-stream serializer: accepts 32-bit word pairs over valid/ready and shifts
// them out MSB-first as two lock-stepped serial streams. A one-entry holding
// buffer lets the next pair load on the last bit of the current frame, so
// back-to-back pairs produce a gapless bitstream.
// Ports:
//   clk  : clock, all logic on rising edge
//   rst  : asynchronous active-high reset
//   bus  : dual_seq_serializer_if.slave (handshake, out_en, serial outputs)
// Optional feature macro: DUAL_SER_PARITY_EN appends one even-parity bit per
// stream to every frame (frame length WIDTH+1).
module dual_seq_serializer
    import dual_ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_seq_serializer_if.slave  bus
);

`ifdef DUAL_SER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          hb_full_q;

    logic at_last;
    logic load;
    logic shift;
    logic clear;
    logic accept;
    logic bit1;
    logic bit2;

    assign at_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    // Loading from IDLE ignores out_en: it puts the MSB on the line, it is not a shift.
    assign load    = hb_full_q && ((state_q == IDLE) || (bus.out_en && at_last));
    assign shift   = (state_q == SHIFT) && bus.out_en && !at_last;
    assign clear   = bus.out_en && at_last && !hb_full_q;

    // The load edge frees the buffer, so a new pair can be taken on that same edge.
    assign bus.in_ready = !hb_full_q || load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hb_full_q <= 1'b0;
        end else begin
            hb_full_q <= accept || (hb_full_q && !load);
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        cnt_q <= '0;
                    end else if (shift) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else if (clear) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef DUAL_SER_PARITY_EN
    logic par_sel;
    assign par_sel = (cnt_q == CW'(WIDTH));
`endif

    ser_shift_lane #(
        .WIDTH (WIDTH)
    ) u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .capture (accept),
        .load    (load),
        .shift   (shift),
        .clear   (clear),
`ifdef DUAL_SER_PARITY_EN
        .par_sel (par_sel),
`endif
        .word    (bus.in_word1),
        .bit_out (bit1)
    );

    ser_shift_lane #(
        .WIDTH (WIDTH)
    ) u_lane2 (
        .clk     (clk),
        .rst     (rst),
        .capture (accept),
        .load    (load),
        .shift   (shift),
        .clear   (clear),
`ifdef DUAL_SER_PARITY_EN
        .par_sel (par_sel),
`endif
        .word    (bus.in_word2),
        .bit_out (bit2)
    );

    assign bus.bit_valid   = (state_q == SHIFT);
    assign bus.seq1        = (state_q == SHIFT) && bit1;
    assign bus.seq2        = (state_q == SHIFT) && bit2;
    assign bus.frame_start = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.frame_last  = at_last;

endmodule

// File: tb/tb_dual_seq_serializer.sv
// Self-checking bench for dual_seq_serializer. Expected bits are pushed to a
// scoreboard queue when a pair is accepted and compared when they appear on
// the serial outputs. Build with DUAL_SER_PARITY_EN to cover the parity frame.
module tb_dual_seq_serializer;
    import dual_ser_pkg::*;

    localparam int unsigned WIDTH = DEF_WIDTH;
`ifdef DUAL_SER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst;

    dual_seq_serializer_if #(.WIDTH(WIDTH)) bus ();

    dual_seq_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Entry: {seq1, seq2, frame_start, frame_last}
    logic [3:0] exp_q[$];
    logic       m_active;
    logic       m_hbfull;
    int         cyc;
    int         bv_first;
    int         bv_last;
    int         bv_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2);
        logic st;
        logic ls;
        for (int i = 0; i < int'(WIDTH); i++) begin
            st = (i == 0);
            ls = (i == int'(FRAME) - 1);
            exp_q.push_back({w1[WIDTH-1-i], w2[WIDTH-1-i], st, ls});
        end
`ifdef DUAL_SER_PARITY_EN
        exp_q.push_back({^w1, ^w2, 1'b0, 1'b1});
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 1'b0;
        m_hbfull = 1'b0;
    endtask

    task automatic mark_reset();
        bv_first = -1;
        bv_last  = -1;
        bv_cnt   = 0;
    endtask

    // Called right after a negedge with inputs set; checks, then advances one clock.
    task automatic tick(output logic acc);
        logic       ld;
        logic       rdy;
        logic       last;
        logic [3:0] e;
        #1;
        ld  = m_hbfull && (!m_active || (bus.out_en && exp_q.size() > 0 && exp_q[0][0]));
        rdy = !m_hbfull || ld;
        e   = (m_active && exp_q.size() > 0) ? exp_q[0] : 4'b0000;
        chk("bit_valid",   bus.bit_valid,   m_active);
        chk("seq1",        bus.seq1,        e[3]);
        chk("seq2",        bus.seq2,        e[2]);
        chk("frame_start", bus.frame_start, e[1]);
        chk("frame_last",  bus.frame_last,  e[0]);
        chk("in_ready",    bus.in_ready,    rdy);
        if (bus.bit_valid) begin
            if (bv_first < 0) bv_first = cyc;
            bv_last = cyc;
            bv_cnt++;
        end
        acc  = bus.in_valid && rdy;
        last = 1'b0;
        if (m_active && bus.out_en && exp_q.size() > 0) begin
            last = exp_q[0][0];
            void'(exp_q.pop_front());
        end
        if (ld) m_active = 1'b1;
        else if (last) m_active = 1'b0;
        m_hbfull = acc || (m_hbfull && !ld);
        if (acc) push_frame(bus.in_word1, bus.in_word2);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_word1 = w1;
        bus.in_word2 = w2;
        for (int i = 0; i < 200; i++) begin
            tick(acc);
            if (acc) break;
        end
        bus.in_valid = 1'b0;
        chk("accepted", acc, 1'b1);
    endtask

    task automatic wait_idle();
        logic acc;
        for (int i = 0; i < 400; i++) begin
            if (!m_active && !m_hbfull) break;
            tick(acc);
        end
        chk("idle_reached", {m_active, m_hbfull}, 2'b00);
        // One more quiet cycle checks that IDLE really shows bit_valid=0.
        tick(acc);
    endtask

    initial begin
        logic acc;
        cyc          = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word1 = '0;
        bus.in_word2 = '0;
        bus.out_en   = 1'b1;
        model_reset();
        mark_reset();
        #1;
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_bit_valid", bus.bit_valid, 1'b0);
        chk("rst_seq1",      bus.seq1,      1'b0);
        chk("rst_seq2",      bus.seq2,      1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single pair, full frame then IDLE.
        mark_reset();
        send(32'h8BF8BDB1, 32'hBBF8AEB1);
        chk("single_first_cycle", bv_cnt, 0);
        wait_idle();
        chk("single_frame_len", bv_last - bv_first + 1, FRAME);
        chk("single_bv_cnt", bv_cnt, FRAME);

        // Three pairs back-to-back: continuous bitstream.
        mark_reset();
        send(32'hDEADBEEF, 32'h01234567);
        send(32'h80000001, 32'h7FFFFFFE);
        send(32'hA5A5A5A5, 32'h5A5A5A5A);
        wait_idle();
        chk("three_bv_cnt", bv_cnt, 3 * FRAME);
        chk("three_span", bv_last - bv_first + 1, 3 * FRAME);

        // out_en low for 5 cycles while bit 7 is on the line.
        mark_reset();
        send(32'hC3C3F00F, 32'h0FF03C3C);
        tick(acc);
        for (int i = 0; i < 7; i++) tick(acc);
        bus.out_en = 1'b0;
        for (int i = 0; i < 5; i++) tick(acc);
        bus.out_en = 1'b1;
        wait_idle();
        chk("stall_frame_len", bv_last - bv_first + 1, FRAME + 5);

        // Offer while buffer is full and no load: must be refused, buffer intact.
        send(32'h11111111, 32'h22222222);
        send(32'h33333333, 32'h44444444);
        bus.in_valid = 1'b1;
        bus.in_word1 = 32'hFFFF0000;
        bus.in_word2 = 32'h0000FFFF;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            chk("refused_when_full", acc, 1'b0);
        end
        bus.in_valid = 1'b0;
        bus.in_word1 = 32'h99999999;
        wait_idle();

        // Reset while bit 10 is on the line.
        send(32'hFEDCBA98, 32'h76543210);
        tick(acc);
        for (int i = 0; i < 10; i++) tick(acc);
        chk("pre_rst_bit_valid", bus.bit_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",    bus.in_ready,    1'b1);
        chk("mid_rst_bit_valid",   bus.bit_valid,   1'b0);
        chk("mid_rst_seq1",        bus.seq1,        1'b0);
        chk("mid_rst_seq2",        bus.seq2,        1'b0);
        chk("mid_rst_frame_start", bus.frame_start, 1'b0);
        chk("mid_rst_frame_last",  bus.frame_last,  1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        mark_reset();
        send(32'h9E3779B9, 32'h6A09E667);
        wait_idle();
        chk("post_rst_frame_len", bv_last - bv_first + 1, FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
